ctrl_pipeline: RTL and testbench
================================

Name: ctrl_pipeline

Overview:
- Receiving end of the decoder's control bundle.
- Carries the eight control fields from ID through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS datapath, along with register addresses.
- Generates load-use stall, branch flush and EX-stage forwarding selects.
- Sits between the instruction decoder and the datapath muxes, register file write port and data memory.

Parameters:
- REG_ADDR_W, 5, register-address width.
- ALU_OP_W, 2, width of alu_op field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  decoder outputs.
- id_alu_op  in  ALU_OP_W  decoder alu_op.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register fields of ID instruction.
- mem_zero  in  1  ALU zero flag registered into EX/MEM.
- ex_reg_dst, ex_alu_src  out  1  EX controls.
- ex_alu_op  out  ALU_OP_W  EX alu_op.
- ex_rs, ex_rt  out  REG_ADDR_W  EX source registers.
- mem_read, mem_write  out  1  MEM controls.
- branch_taken  out  1  combinational: mem_branch & mem_zero.
- wb_reg_write, wb_mem_to_reg  out  1  WB controls.
- wb_reg  out  REG_ADDR_W  WB destination register.
- forward_a, forward_b  out  2  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- pc_write_en, if_id_write_en  out  1  low during stall.
- if_id_flush  out  1  equals branch_taken.

Behaviour:
- Reset: all pipeline control bits, register addresses and the valid flag clear to 0 (every stage is a bubble).
  - Outputs after reset: forward_a/b = 00, pc_write_en = 1, if_id_write_en = 1, branch_taken = 0, if_id_flush = 0.
  - rst asserted mid-operation discards all in-flight instructions at the next edge.
- Latency: ID fields appear on ex_* 1 cycle later, on mem_* after 2 cycles, and on wb_* after 3 cycles.
- Destination select: the register that becomes wb_reg is computed when entering EX/MEM as reg_dst ? rd : rt.
  - Destination 0 never forwards, but still flows.
- Load-use stall (combinational):
  - Condition: stall = id_valid & ex_mem_read & ex_rt≠0 & (ex_rt==id_rs | ex_rt==id_rt). Comparison is conservative for all opcodes.
  - On stall: pc_write_en = 0, if_id_write_en = 0, and ID/EX loads a bubble (all controls 0).
  - The stall lasts exactly 1 cycle per hazard.
- Branch (resolved in MEM):
  - When branch_taken = 1, ID/EX and EX/MEM load bubbles at the next edge and if_id_flush = 1.
  - Flush has priority over stall: stall is forced 0, and pc_write_en = 1 so the target PC loads.
- Forwarding for source s ∈ {ex_rs, ex_rt}:
  - 10 if EX/MEM reg_write & EX/MEM dest≠0 & dest==s.
  - Else 01 if MEM/WB reg_write & wb_reg≠0 & wb_reg==s.
  - Else 00. EX/MEM wins when both match.
- id_valid = 0 inserts a bubble into ID/EX.
- Stores and branches never assert reg_write downstream, so they never forward.

Decomposition:
- Existing cpu_constant_library: add FWD_REGFILE=2'b00, FWD_EX_MEM=2'b10 and FWD_MEM_WB=2'b01.
- Sub-module hazard_forward_unit (combinational stall/forward logic), instantiated once. Pipeline registers stay in ctrl_pipeline.

Test Plan:
- R-type add $3,$1,$2 (reg_dst=1, reg_write=1, alu_op=2) -> ex_alu_op=2 at cycle 1, wb_reg=3 and wb_reg_write=1 at cycle 3, no stall.
- lw $4 then add $5,$4,$1 back-to-back -> pc_write_en=0 and if_id_write_en=0 for exactly 1 cycle, bubble in EX. Next cycle forward_a=01.
- add $6,... then sub $7,$6,$6 -> forward_a=forward_b=10. With an unrelated instruction between them -> both 01.
- beq (branch=1) with mem_zero=1 in MEM -> branch_taken=1, if_id_flush=1, and the following two younger instructions carry no reg_write/mem_write. With mem_zero=0 -> no flush.
- Load-use hazard in ID coincident with branch_taken -> stall=0, pc_write_en=1, flush wins.
- Writes to $0 (reg_write=1, dest 0) followed by use of $0 -> forward_a=00. Assert rst mid-stream -> all outputs at reset values after the next edge.

Source files
------------

// File: rtl/cpu_constant_library.sv
// Shared constants and control-bundle types for the MIPS pipeline control path.
package cpu_constant_library;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EX_MEM  = 2'b10;
   localparam logic [1:0] FWD_MEM_WB  = 2'b01;

   // Decoder control bundle as held in ID/EX.
   typedef struct packed {
      logic reg_dst;
      logic branch;
      logic mem_read;
      logic mem_to_reg;
      logic mem_write;
      logic alu_src;
      logic reg_write;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
   } ex_mem_ctrl_t;

   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
   } mem_wb_ctrl_t;

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational load-use stall detection and EX-stage operand forwarding selects.
module hazard_forward_unit
   import cpu_constant_library::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rs_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_i,
   input  logic                  mem_reg_write_i,
   input  logic [REG_ADDR_W-1:0] mem_dest_i,
   input  logic                  wb_reg_write_i,
   input  logic [REG_ADDR_W-1:0] wb_dest_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic [1:0]            forward_a_o,
   output logic [1:0]            forward_b_o
);

   // The younger producer (EX/MEM) wins when both stages target the same register.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] src,
      input logic                  mem_rw,
      input logic [REG_ADDR_W-1:0] mem_dest,
      input logic                  wb_rw,
      input logic [REG_ADDR_W-1:0] wb_dest
   );
      logic [1:0] sel;
      sel = FWD_REGFILE;
      if (mem_rw && (mem_dest != '0) && (mem_dest == src)) begin
         sel = FWD_EX_MEM;
      end else if (wb_rw && (wb_dest != '0) && (wb_dest == src)) begin
         sel = FWD_MEM_WB;
      end
      return sel;
   endfunction

   logic load_use;

   always_comb begin
      load_use = id_valid_i & ex_mem_read_i & (ex_rt_i != '0) &
                 ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
      stall_o  = load_use & ~flush_i;
      forward_a_o = fwd_sel(ex_rs_i, mem_reg_write_i, mem_dest_i, wb_reg_write_i, wb_dest_i);
      forward_b_o = fwd_sel(ex_rt_i, mem_reg_write_i, mem_dest_i, wb_reg_write_i, wb_dest_i);
   end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoder control fields through ID/EX, EX/MEM and MEM/WB and drives
// the stall, flush and forwarding controls of the 5-stage MIPS datapath.
module ctrl_pipeline
   import cpu_constant_library::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int ALU_OP_W   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic                  id_reg_dst,
   input  logic                  id_branch,
   input  logic                  id_mem_read,
   input  logic                  id_mem_to_reg,
   input  logic                  id_mem_write,
   input  logic                  id_alu_src,
   input  logic                  id_reg_write,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  mem_zero,
   output logic                  ex_reg_dst,
   output logic                  ex_alu_src,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  branch_taken,
   output logic                  wb_reg_write,
   output logic                  wb_mem_to_reg,
   output logic [REG_ADDR_W-1:0] wb_reg,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  pc_write_en,
   output logic                  if_id_write_en,
   output logic                  if_id_flush
);

   id_ex_ctrl_t           id_ctrl;
   id_ex_ctrl_t           ex_ctrl_q, ex_ctrl_d;
   logic                  ex_valid_q, ex_valid_d;
   logic [ALU_OP_W-1:0]   ex_alu_op_q, ex_alu_op_d;
   logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
   logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;

   ex_mem_ctrl_t          mem_ctrl_q, mem_ctrl_d;
   logic                  mem_valid_q, mem_valid_d;
   logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;

   mem_wb_ctrl_t          wb_ctrl_q, wb_ctrl_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [REG_ADDR_W-1:0] wb_reg_q, wb_reg_d;

   logic                  stall;
   logic                  taken;
   logic                  wb_rw;

   assign id_ctrl = '{reg_dst:    id_reg_dst,
                      branch:     id_branch,
                      mem_read:   id_mem_read,
                      mem_to_reg: id_mem_to_reg,
                      mem_write:  id_mem_write,
                      alu_src:    id_alu_src,
                      reg_write:  id_reg_write};

   assign taken = mem_valid_q & mem_ctrl_q.branch & mem_zero;
   assign wb_rw = wb_valid_q & wb_ctrl_q.reg_write;

   hazard_forward_unit #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_hazard (
      .id_valid_i      (id_valid),
      .id_rs_i         (id_rs),
      .id_rt_i         (id_rt),
      .ex_mem_read_i   (ex_ctrl_q.mem_read),
      .ex_rs_i         (ex_rs_q),
      .ex_rt_i         (ex_rt_q),
      .mem_reg_write_i (mem_ctrl_q.reg_write),
      .mem_dest_i      (mem_dest_q),
      .wb_reg_write_i  (wb_rw),
      .wb_dest_i       (wb_reg_q),
      .flush_i         (taken),
      .stall_o         (stall),
      .forward_a_o     (forward_a),
      .forward_b_o     (forward_b)
   );

   // ID -> EX: stalls, flushes and invalid slots all load a bubble.
   always_comb begin
      ex_valid_d  = 1'b0;
      ex_ctrl_d   = '0;
      ex_alu_op_d = '0;
      ex_rs_d     = '0;
      ex_rt_d     = '0;
      ex_rd_d     = '0;
      if (id_valid && !stall && !taken) begin
         ex_valid_d  = 1'b1;
         ex_ctrl_d   = id_ctrl;
         ex_alu_op_d = id_alu_op;
         ex_rs_d     = id_rs;
         ex_rt_d     = id_rt;
         ex_rd_d     = id_rd;
      end
   end

   // EX -> MEM: destination register is resolved here.
   always_comb begin
      mem_valid_d = 1'b0;
      mem_ctrl_d  = '0;
      mem_dest_d  = '0;
      if (ex_valid_q && !taken) begin
         mem_valid_d = 1'b1;
         mem_ctrl_d  = '{branch:     ex_ctrl_q.branch,
                         mem_read:   ex_ctrl_q.mem_read,
                         mem_write:  ex_ctrl_q.mem_write,
                         mem_to_reg: ex_ctrl_q.mem_to_reg,
                         reg_write:  ex_ctrl_q.reg_write};
         mem_dest_d  = ex_ctrl_q.reg_dst ? ex_rd_q : ex_rt_q;
      end
   end

   // MEM -> WB: the branch itself retires, so this stage is never squashed.
   always_comb begin
      wb_valid_d = mem_valid_q;
      wb_ctrl_d  = '{mem_to_reg: mem_ctrl_q.mem_to_reg,
                     reg_write:  mem_ctrl_q.reg_write};
      wb_reg_d   = mem_dest_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q  <= 1'b0;
         ex_ctrl_q   <= '0;
         ex_alu_op_q <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rd_q     <= '0;
         mem_valid_q <= 1'b0;
         mem_ctrl_q  <= '0;
         mem_dest_q  <= '0;
         wb_valid_q  <= 1'b0;
         wb_ctrl_q   <= '0;
         wb_reg_q    <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_ctrl_q   <= ex_ctrl_d;
         ex_alu_op_q <= ex_alu_op_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_rd_q     <= ex_rd_d;
         mem_valid_q <= mem_valid_d;
         mem_ctrl_q  <= mem_ctrl_d;
         mem_dest_q  <= mem_dest_d;
         wb_valid_q  <= wb_valid_d;
         wb_ctrl_q   <= wb_ctrl_d;
         wb_reg_q    <= wb_reg_d;
      end
   end

   assign ex_reg_dst     = ex_ctrl_q.reg_dst;
   assign ex_alu_src     = ex_ctrl_q.alu_src;
   assign ex_alu_op      = ex_alu_op_q;
   assign ex_rs          = ex_rs_q;
   assign ex_rt          = ex_rt_q;
   assign mem_read       = mem_ctrl_q.mem_read;
   assign mem_write      = mem_ctrl_q.mem_write;
   assign branch_taken   = taken;
   assign wb_reg_write   = wb_rw;
   assign wb_mem_to_reg  = wb_ctrl_q.mem_to_reg;
   assign wb_reg         = wb_reg_q;
   assign pc_write_en    = ~stall;
   assign if_id_write_en = ~stall;
   assign if_id_flush    = taken;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: hand-written vector table plus random instruction stream
// compared every cycle against an instruction-level reference model.
module tb_ctrl_pipeline;

   typedef struct packed {
      logic       valid;
      logic       reg_dst;
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] alu_op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } instr_t;

   typedef struct packed {
      logic       ex_reg_dst;
      logic       ex_alu_src;
      logic [1:0] ex_alu_op;
      logic [4:0] ex_rs;
      logic [4:0] ex_rt;
      logic       mem_read;
      logic       mem_write;
      logic       branch_taken;
      logic       wb_reg_write;
      logic       wb_mem_to_reg;
      logic [4:0] wb_reg;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       pc_we;
      logic       ifid_we;
      logic       flush;
   } out_t;

   typedef enum int {F_NONE, F_EX_ALU_OP, F_EX_REG_DST, F_EX_RS, F_MEM_READ, F_MEM_WRITE,
                     F_BT, F_FLUSH, F_WB_RW, F_WB_REG, F_FA, F_FB, F_PC_WE, F_IFID_WE} fld_e;

   typedef struct {
      instr_t id;
      logic   mz;
      logic   rs;
      fld_e   f1;
      int     v1;
      fld_e   f2;
      int     v2;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
   logic       id_mem_write, id_alu_src, id_reg_write;
   logic [1:0] id_alu_op;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       mem_zero;
   logic       ex_reg_dst, ex_alu_src;
   logic [1:0] ex_alu_op;
   logic [4:0] ex_rs, ex_rt;
   logic       mem_read, mem_write, branch_taken, wb_reg_write, wb_mem_to_reg;
   logic [4:0] wb_reg;
   logic [1:0] forward_a, forward_b;
   logic       pc_write_en, if_id_write_en, if_id_flush;

   int total = 0;
   int bad   = 0;

   instr_t m_ex  = '0;
   instr_t m_mem = '0;
   instr_t m_wb  = '0;
   out_t   dut_o;

   always #5 clk = ~clk;

   ctrl_pipeline #(.REG_ADDR_W(5), .ALU_OP_W(2)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_mem_read(id_mem_read),
      .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
      .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_read(mem_read), .mem_write(mem_write),
      .branch_taken(branch_taken), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_reg(wb_reg), .forward_a(forward_a), .forward_b(forward_b),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush)
   );

   always_comb begin
      dut_o = '{ex_reg_dst: ex_reg_dst, ex_alu_src: ex_alu_src, ex_alu_op: ex_alu_op,
                ex_rs: ex_rs, ex_rt: ex_rt, mem_read: mem_read, mem_write: mem_write,
                branch_taken: branch_taken, wb_reg_write: wb_reg_write,
                wb_mem_to_reg: wb_mem_to_reg, wb_reg: wb_reg, fa: forward_a, fb: forward_b,
                pc_we: pc_write_en, ifid_we: if_id_write_en, flush: if_id_flush};
   end

   function automatic instr_t mk_r(input int rd, input int rs, input int rt);
      instr_t i = '0;
      i.valid = 1'b1; i.reg_dst = 1'b1; i.reg_write = 1'b1; i.alu_op = 2'd2;
      i.rd = 5'(rd); i.rs = 5'(rs); i.rt = 5'(rt);
      return i;
   endfunction

   function automatic instr_t mk_lw(input int rt, input int rs);
      instr_t i = '0;
      i.valid = 1'b1; i.mem_read = 1'b1; i.mem_to_reg = 1'b1; i.alu_src = 1'b1;
      i.reg_write = 1'b1; i.rt = 5'(rt); i.rs = 5'(rs);
      return i;
   endfunction

   function automatic instr_t mk_sw(input int rt, input int rs);
      instr_t i = '0;
      i.valid = 1'b1; i.mem_write = 1'b1; i.alu_src = 1'b1; i.rt = 5'(rt); i.rs = 5'(rs);
      return i;
   endfunction

   function automatic instr_t mk_beq(input int rs, input int rt);
      instr_t i = '0;
      i.valid = 1'b1; i.branch = 1'b1; i.alu_op = 2'd1; i.rs = 5'(rs); i.rt = 5'(rt);
      return i;
   endfunction

   function automatic instr_t mk_rand();
      instr_t i;
      int k = $urandom_range(0, 5);
      int a = $urandom_range(0, 7);
      int b = $urandom_range(0, 7);
      int c = $urandom_range(0, 7);
      case (k)
         0:       begin i = instr_t'($urandom); i.valid = 1'b0; end
         1, 2:    i = mk_r(a, b, c);
         3:       i = mk_lw(a, b);
         4:       i = mk_sw(a, b);
         default: i = mk_beq(a, b);
      endcase
      return i;
   endfunction

   // Reference model: one instruction record per stage, rules taken straight from the hazard definitions.
   function automatic logic [4:0] dest_of(input instr_t i);
      return i.reg_dst ? i.rd : i.rt;
   endfunction

   function automatic logic [1:0] fwd_of(input logic [4:0] s);
      if (m_mem.reg_write && dest_of(m_mem) != 5'd0 && dest_of(m_mem) == s) return 2'b10;
      if (m_wb.reg_write && dest_of(m_wb) != 5'd0 && dest_of(m_wb) == s) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic model_taken(input logic mz);
      return m_mem.branch & mz;
   endfunction

   function automatic logic model_stall(input instr_t id, input logic mz);
      return !model_taken(mz) && id.valid && m_ex.mem_read && m_ex.rt != 5'd0 &&
             (m_ex.rt == id.rs || m_ex.rt == id.rt);
   endfunction

   function automatic out_t model_out(input instr_t id, input logic mz);
      out_t o;
      logic st = model_stall(id, mz);
      o.ex_reg_dst    = m_ex.reg_dst;
      o.ex_alu_src    = m_ex.alu_src;
      o.ex_alu_op     = m_ex.alu_op;
      o.ex_rs         = m_ex.rs;
      o.ex_rt         = m_ex.rt;
      o.mem_read      = m_mem.mem_read;
      o.mem_write     = m_mem.mem_write;
      o.branch_taken  = model_taken(mz);
      o.wb_reg_write  = m_wb.reg_write;
      o.wb_mem_to_reg = m_wb.mem_to_reg;
      o.wb_reg        = dest_of(m_wb);
      o.fa            = fwd_of(m_ex.rs);
      o.fb            = fwd_of(m_ex.rt);
      o.pc_we         = !st;
      o.ifid_we       = !st;
      o.flush         = model_taken(mz);
      return o;
   endfunction

   task automatic model_step(input instr_t id, input logic mz, input logic r);
      logic bt = model_taken(mz);
      logic st = model_stall(id, mz);
      if (r) begin
         m_ex = '0; m_mem = '0; m_wb = '0;
      end else begin
         m_wb  = m_mem;
         m_mem = bt ? '0 : m_ex;
         m_ex  = (bt || st || !id.valid) ? '0 : id;
      end
   endtask

   function automatic int field_of(input out_t o, input fld_e f);
      case (f)
         F_EX_ALU_OP:  return int'(o.ex_alu_op);
         F_EX_REG_DST: return int'(o.ex_reg_dst);
         F_EX_RS:      return int'(o.ex_rs);
         F_MEM_READ:   return int'(o.mem_read);
         F_MEM_WRITE:  return int'(o.mem_write);
         F_BT:         return int'(o.branch_taken);
         F_FLUSH:      return int'(o.flush);
         F_WB_RW:      return int'(o.wb_reg_write);
         F_WB_REG:     return int'(o.wb_reg);
         F_FA:         return int'(o.fa);
         F_FB:         return int'(o.fb);
         F_PC_WE:      return int'(o.pc_we);
         F_IFID_WE:    return int'(o.ifid_we);
         default:      return -1;
      endcase
   endfunction

   task automatic check_vec(input string tag, input out_t got, input out_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: outputs got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic check_fld(input string tag, input out_t got, input fld_e f, input int want);
      if (f != F_NONE) begin
         total++;
         if (field_of(got, f) != want) begin
            bad++;
            $display("FAIL %s field=%s: got=%0d want=%0d", tag, f.name(), field_of(got, f), want);
         end
      end
   endtask

   task automatic apply(input instr_t id, input logic mz, input logic r);
      rst           = r;
      id_valid      = id.valid;
      id_reg_dst    = id.reg_dst;
      id_branch     = id.branch;
      id_mem_read   = id.mem_read;
      id_mem_to_reg = id.mem_to_reg;
      id_mem_write  = id.mem_write;
      id_alu_src    = id.alu_src;
      id_reg_write  = id.reg_write;
      id_alu_op     = id.alu_op;
      id_rs         = id.rs;
      id_rt         = id.rt;
      id_rd         = id.rd;
      mem_zero      = mz;
   endtask

   task automatic run_cycle(input instr_t id, input logic mz, input logic r, input string tag,
                            output out_t got, output out_t want);
      @(negedge clk);
      apply(id, mz, r);
      #1;
      want = model_out(id, mz);
      got  = dut_o;
      check_vec(tag, got, want);
      model_step(id, mz, r);
   endtask

   function automatic vec_t row(input instr_t id, input logic mz, input logic r,
                                input fld_e f1, input int v1, input fld_e f2, input int v2);
      vec_t v;
      v.id = id; v.mz = mz; v.rs = r; v.f1 = f1; v.v1 = v1; v.f2 = f2; v.v2 = v2;
      return v;
   endfunction

   initial begin
      vec_t   tbl[$];
      out_t   got, want, rst_vec;
      instr_t nop = '0;
      instr_t cur;

      apply(nop, 1'b0, 1'b1);
      repeat (2) @(posedge clk);

      rst_vec = '0;
      rst_vec.pc_we = 1'b1;
      rst_vec.ifid_we = 1'b1;
      run_cycle(nop, 1'b0, 1'b0, "reset_model", got, want);
      check_vec("reset_state", got, rst_vec);

      // R-type latency
      tbl.push_back(row(mk_r(3, 1, 2), 0, 0, F_PC_WE, 1, F_IFID_WE, 1));
      tbl.push_back(row(nop, 0, 0, F_EX_ALU_OP, 2, F_EX_REG_DST, 1));
      tbl.push_back(row(nop, 0, 0, F_FA, 0, F_NONE, 0));
      tbl.push_back(row(nop, 0, 0, F_WB_REG, 3, F_WB_RW, 1));
      // load-use stall
      tbl.push_back(row(mk_lw(4, 1), 0, 0, F_PC_WE, 1, F_NONE, 0));
      tbl.push_back(row(mk_r(5, 4, 1), 0, 0, F_PC_WE, 0, F_IFID_WE, 0));
      tbl.push_back(row(mk_r(5, 4, 1), 0, 0, F_PC_WE, 1, F_EX_ALU_OP, 0));
      tbl.push_back(row(nop, 0, 0, F_FA, 1, F_EX_RS, 4));
      tbl.push_back(row(nop, 0, 0, F_NONE, 0, F_NONE, 0));
      // EX/MEM forwarding, then MEM/WB forwarding
      tbl.push_back(row(mk_r(6, 1, 2), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(7, 6, 6), 0, 0, F_PC_WE, 1, F_NONE, 0));
      tbl.push_back(row(nop, 0, 0, F_FA, 2, F_FB, 2));
      tbl.push_back(row(mk_r(6, 1, 2), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(8, 9, 9), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(7, 6, 6), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(nop, 0, 0, F_FA, 1, F_FB, 1));
      // taken branch squashes two younger instructions
      tbl.push_back(row(mk_beq(1, 2), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_sw(3, 1), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(11, 1, 2), 1, 0, F_BT, 1, F_FLUSH, 1));
      tbl.push_back(row(nop, 0, 0, F_MEM_WRITE, 0, F_EX_ALU_OP, 0));
      tbl.push_back(row(nop, 0, 0, F_WB_REG, 0, F_BT, 0));
      tbl.push_back(row(nop, 0, 0, F_WB_RW, 0, F_WB_REG, 0));
      // not-taken branch
      tbl.push_back(row(mk_beq(1, 2), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(10, 1, 2), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(11, 1, 2), 0, 0, F_BT, 0, F_FLUSH, 0));
      tbl.push_back(row(nop, 0, 0, F_EX_ALU_OP, 2, F_NONE, 0));
      tbl.push_back(row(nop, 0, 0, F_WB_REG, 10, F_WB_RW, 1));
      tbl.push_back(row(nop, 0, 0, F_NONE, 0, F_NONE, 0));
      // load-use coincident with taken branch
      tbl.push_back(row(mk_beq(1, 2), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_lw(4, 1), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(5, 4, 1), 1, 0, F_PC_WE, 1, F_FLUSH, 1));
      tbl.push_back(row(nop, 0, 0, F_MEM_READ, 0, F_EX_RS, 0));
      tbl.push_back(row(nop, 0, 0, F_NONE, 0, F_NONE, 0));
      // writes to $0 never forward but still flow
      tbl.push_back(row(mk_r(0, 1, 2), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(5, 0, 0), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(nop, 0, 0, F_FA, 0, F_FB, 0));
      tbl.push_back(row(nop, 0, 0, F_WB_RW, 1, F_WB_REG, 0));
      // reset mid-stream
      tbl.push_back(row(mk_r(3, 1, 2), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_lw(4, 1), 0, 0, F_NONE, 0, F_NONE, 0));
      tbl.push_back(row(mk_r(5, 4, 1), 0, 1, F_PC_WE, 0, F_NONE, 0));
      tbl.push_back(row(nop, 0, 0, F_MEM_READ, 0, F_WB_REG, 0));
      tbl.push_back(row(nop, 0, 0, F_WB_RW, 0, F_PC_WE, 1));

      foreach (tbl[i]) begin
         string tag = $sformatf("row%0d", i);
         run_cycle(tbl[i].id, tbl[i].mz, tbl[i].rs, tag, got, want);
         check_fld(tag, got, tbl[i].f1, tbl[i].v1);
         check_fld(tag, got, tbl[i].f2, tbl[i].v2);
      end

      // Random stream; a stalled ID instruction is re-presented as IF/ID would hold it.
      cur = mk_rand();
      for (int n = 0; n < 2000; n++) begin
         logic r = ($urandom_range(0, 99) == 0);
         logic mz = 1'($urandom);
         run_cycle(cur, mz, r, $sformatf("rand%0d", n), got, want);
         if (r || want.pc_we) cur = mk_rand();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
